// File: rtl/rata_a_pkg.sv
// Shared state encoding and default constants for the rata_a attestation monitor.
package rata_a_pkg;

  typedef enum logic [1:0] {
    NOT_MOD = 2'b00,
    MOD     = 2'b01,
    RESET   = 2'b10
  } state_e;

  localparam logic [31:0] RATA_A_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/rata_a_reset_timer.sv
// Saturating hold counter for the RESET state; used by rata_a only when
// RATA_A_RESET_HOLD_EN is defined.
module rata_a_reset_timer #(
  parameter int unsigned MIN_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_done
);

  localparam int unsigned CntW = (MIN_CYCLES > 0) ? $clog2(MIN_CYCLES + 1) : 1;

  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_inc;

  // o_done counts the current cycle too, so an exit edge sees MIN_CYCLES cycles in RESET.
  always_comb begin
    w_cnt_inc = (r_cnt >= CntW'(MIN_CYCLES)) ? r_cnt : r_cnt + 1'b1;
    o_done    = (w_cnt_inc >= CntW'(MIN_CYCLES));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_cnt_inc;
    end
  end

endmodule

// File: rtl/rata_a.sv
// RATA variant A monitor: grants setLMT after attested-region writes and forces reset on
// LMT-region write attempts. Optional minimum RESET hold via macro RATA_A_RESET_HOLD_EN.
module rata_a
  import rata_a_pkg::*;
#(
  parameter int unsigned         PC_WIDTH         = 32,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR     = PC_WIDTH'(RATA_A_RESET_VECTOR),
  parameter int unsigned         MIN_RESET_CYCLES = 2
) (
  input  logic                clk,
  input  logic                start_signal,
  input  logic                Mod_Mem_AR,
  input  logic                Mod_Mem_LMT,
  input  logic [PC_WIDTH-1:0] PC,
  output logic                setLMT,
  output logic                reset
);

  state_e current_state;
  state_e w_next_state;
  logic   w_hold_done;

`ifdef RATA_A_RESET_HOLD_EN
  // Clearing whenever outside RESET is equivalent to clearing on RESET entry.
  rata_a_reset_timer #(
    .MIN_CYCLES(MIN_RESET_CYCLES)
  ) u_reset_timer (
    .clk   (clk),
    .rst   (start_signal),
    .i_clr (current_state != RESET),
    .i_en  (current_state == RESET),
    .o_done(w_hold_done)
  );
`else
  assign w_hold_done = 1'b1;
`endif

  always_ff @(posedge clk or posedge start_signal) begin
    if (start_signal) begin
      current_state <= MOD;
    end else begin
      current_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = RESET;
    case (current_state)
      NOT_MOD: begin
        if (Mod_Mem_LMT)     w_next_state = RESET;
        else if (Mod_Mem_AR) w_next_state = MOD;
        else                 w_next_state = NOT_MOD;
      end
      MOD: begin
        if (Mod_Mem_LMT)     w_next_state = RESET;
        else if (Mod_Mem_AR) w_next_state = MOD;
        else                 w_next_state = NOT_MOD;
      end
      RESET: begin
        if (Mod_Mem_LMT)                              w_next_state = RESET;
        else if ((PC == RESET_VECTOR) && w_hold_done) w_next_state = MOD;
        else                                          w_next_state = RESET;
      end
      default: w_next_state = RESET;
    endcase
  end

  always_comb begin
    setLMT = (current_state == MOD);
    reset  = (current_state == RESET);
  end

endmodule

// File: tb/tb_rata_a.sv
// Directed self-checking bench for rata_a; expectations follow RATA_A_RESET_HOLD_EN if defined.
module tb_rata_a;
  import rata_a_pkg::*;

  logic        clk = 1'b0;
  logic        start_signal = 1'b0;
  logic        Mod_Mem_AR = 1'b0;
  logic        Mod_Mem_LMT = 1'b0;
  logic [31:0] PC = 32'h1003;
  logic        setLMT;
  logic        reset;

  int n_chk  = 0;
  int n_pass = 0;

  rata_a dut (
    .clk         (clk),
    .start_signal(start_signal),
    .Mod_Mem_AR  (Mod_Mem_AR),
    .Mod_Mem_LMT (Mod_Mem_LMT),
    .PC          (PC),
    .setLMT      (setLMT),
    .reset       (reset)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_st(input string tag, input logic [1:0] st, input logic slmt,
                          input logic rst);
    check({tag, ".state"}, {30'b0, dut.current_state}, {30'b0, st});
    check({tag, ".setLMT"}, {31'b0, setLMT}, {31'b0, slmt});
    check({tag, ".reset"}, {31'b0, reset}, {31'b0, rst});
  endtask

  initial begin
    // 1: start pulse, then AR write cycle
    #1 start_signal = 1'b1;
    #1 check_st("t1_async_start", 2'b01, 1'b1, 1'b0);
    step();
    check_st("t1_start_held", 2'b01, 1'b1, 1'b0);
    start_signal = 1'b0;
    step();
    check_st("t1_idle", 2'b00, 1'b0, 1'b0);
    Mod_Mem_AR = 1'b1;
    step();
    check_st("t1_ar_write", 2'b01, 1'b1, 1'b0);
    Mod_Mem_AR = 1'b0;
    step();
    check_st("t1_ar_done", 2'b00, 1'b0, 1'b0);

    // 2: LMT write forces RESET; release only on PC == vector
    Mod_Mem_LMT = 1'b1;
    step();
    check_st("t2_lmt", 2'b10, 1'b0, 1'b1);
    Mod_Mem_LMT = 1'b0;
    PC = 32'h1002;
    step();
    check_st("t2_pc1002", 2'b10, 1'b0, 1'b1);
    PC = 32'h0500;
    step();
    check_st("t2_pc0500", 2'b10, 1'b0, 1'b1);
    PC = 32'h0000;
    step();
    check_st("t2_pc0", 2'b01, 1'b1, 1'b0);
    PC = 32'h1003;
    step();
    check_st("t2_after", 2'b00, 1'b0, 1'b0);

    // 3: LMT write while in MOD
    start_signal = 1'b1;
    #2 check_st("t3_start", 2'b01, 1'b1, 1'b0);
    start_signal = 1'b0;
    Mod_Mem_LMT = 1'b1;
    step();
    check_st("t3_lmt_in_mod", 2'b10, 1'b0, 1'b1);
    Mod_Mem_LMT = 1'b0;

    // 4: simultaneous AR and LMT from NOT_MOD
    start_signal = 1'b1;
    #2 start_signal = 1'b0;
    step();
    check_st("t4_idle", 2'b00, 1'b0, 1'b0);
    Mod_Mem_AR = 1'b1;
    Mod_Mem_LMT = 1'b1;
    step();
    check_st("t4_both", 2'b10, 1'b0, 1'b1);
    Mod_Mem_AR = 1'b0;

    // 5: LMT keeps RESET despite PC match; async start mid-cycle
    PC = 32'h0000;
    step();
    check_st("t5_lmt_hold", 2'b10, 1'b0, 1'b1);
    #3 start_signal = 1'b1;
    #1 check_st("t5_async", 2'b01, 1'b1, 1'b0);
    start_signal = 1'b0;
    Mod_Mem_LMT = 1'b0;
    PC = 32'h1003;
    step();
    check_st("t5_release", 2'b00, 1'b0, 1'b0);

    // 6: RESET entered with PC already at the vector
    PC = 32'h0000;
    Mod_Mem_LMT = 1'b1;
    step();
    check_st("t6_enter", 2'b10, 1'b0, 1'b1);
    Mod_Mem_LMT = 1'b0;
    step();
`ifdef RATA_A_RESET_HOLD_EN
    check_st("t6_hold2", 2'b10, 1'b0, 1'b1);
    step();
`endif
    check_st("t6_exit", 2'b01, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
